// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF->ID stage register with a 2-entry skid buffer,
// hold/flush control and a saturating count of flushed entries.
module if_id_skid_reg #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int SIDE_W = 2,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(32'h0000_0000),
    parameter int CNT_W = 16
) (
    input  logic              clk_100MHz,
    input  logic              srst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [INST_W-1:0] in_inst_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [SIDE_W-1:0] in_side_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [INST_W-1:0] out_inst_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [SIDE_W-1:0] out_side_o,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
        logic [SIDE_W-1:0] side;
    } if_id_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q;
    state_e           state_d;
    if_id_t           main_q;
    if_id_t           main_d;
    if_id_t           skid_q;
    if_id_t           skid_d;
    if_id_t           in_beat;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W+1:0] cnt_sum;
    logic [1:0]       occ;
    logic             push;
    logic             pop;

    assign in_beat = {in_inst_i, in_addr_i, in_side_i};

    assign in_ready_o  = (state_q != FULL) && !hold_i && !flush_i;
    assign out_valid_o = (state_q != EMPTY) && !hold_i && !flush_i;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    assign out_inst_o = out_valid_o ? main_q.inst : NOP_INST;
    assign out_addr_o = out_valid_o ? main_q.addr : RESET_ADDR;
    assign out_side_o = out_valid_o ? main_q.side : '0;

    assign flush_cnt_o = cnt_q;

    always_comb begin
        occ = 2'd0;
        case (state_q)
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    // Widened sum so the saturation compare never sees a wrapped value
    assign cnt_sum = {2'b00, cnt_q} + {{CNT_W{1'b0}}, occ};

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_sum > {2'b00, CNT_MAX})
            cnt_d = CNT_MAX;
        else
            cnt_d = cnt_sum[CNT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_beat;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b11: main_d = in_beat;
                        2'b10: begin
                            state_d = FULL;
                            skid_d  = in_beat;
                        end
                        2'b01: state_d = EMPTY;
                        default: state_d = ONE;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (srst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i)
                cnt_q <= cnt_d;
        end
    end

    // Payload needs no reset: it is only visible behind a valid state
    always_ff @(posedge clk_100MHz) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Parametrised IF→ID pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Carries instruction word, instruction address and a sideband field (prediction/exception bits) from fetch to decode.
- Supports pipeline hold (stall) and flush (jump/exception kill), and injects a deterministic NOP bubble on empty.
- Has a saturating counter of flushed entries for performance monitoring.

Parameters:
INST_W, 32, instruction width
ADDR_W, 32, instruction address width
SIDE_W, 2, sideband width (≥1)
NOP_INST, 32'h0000_0013, payload presented when invalid (addi x0,x0,0)
RESET_ADDR, 32'h0000_0000, address presented when invalid
CNT_W, 16, flush counter width

Ports:
clk_100MHz  in  1  clock, rising edge
srst  in  1  synchronous reset, active-high
in_valid_i  in  1  upstream beat valid
in_ready_o  out  1  stage can accept beat
in_inst_i  in  INST_W  upstream instruction
in_addr_i  in  ADDR_W  upstream address
in_side_i  in  SIDE_W  upstream sideband
out_valid_o  out  1  downstream beat valid
out_ready_i  in  1  downstream accepts beat
out_inst_o  out  INST_W  instruction to decode
out_addr_o  out  ADDR_W  address to decode
out_side_o  out  SIDE_W  sideband to decode
hold_i  in  1  stall: freeze stage
flush_i  in  1  kill all buffered entries
flush_cnt_o  out  CNT_W  saturating count of discarded entries

Behaviour:
- Storage: main register (head) and skid register. State: EMPTY (0 entries), ONE (main valid), FULL (main+skid valid).
- Reset (srst=1 at clock edge): state→EMPTY, flush_cnt_o→0. Reset overrides flush and hold. While in reset and after it: out_valid_o=0, out_inst_o=NOP_INST, out_addr_o=RESET_ADDR, out_side_o=0, and in_ready_o=1 unless hold_i or flush_i.
- in_ready_o = (state≠FULL) && !hold_i && !flush_i. Combinational only from registered state and the hold/flush controls, never from in_valid_i or out_ready_i.
- out_valid_o = (state≠EMPTY) && !hold_i && !flush_i.
- out_* payload = main register when out_valid_o=1. Otherwise NOP_INST / RESET_ADDR / 0.
- push = in_valid_i && in_ready_o; pop = out_valid_o && out_ready_i.
- Priority: srst > flush_i > hold_i > normal. Flush beats hold so that a redirect arriving during a stall is not lost.
- Normal transitions:
  - EMPTY: push→ONE, main←in.
  - ONE: push&pop→ONE, main←in. push only→FULL, skid←in. pop only→EMPTY. Neither→ONE, unchanged.
  - FULL: no push possible. pop→ONE, main←skid. No pop→FULL, unchanged.
- Latency: 1 cycle from push to out_valid_o. Sustains 1 beat/cycle with out_ready_i held high.
- Backpressure: while out_valid_o=1 and out_ready_i=0 and no hold/flush, payload stays stable cycle to cycle.
- hold_i=1: no push, no pop, state and payload registers frozen. Outputs show the bubble values. Same state and payload reappear when hold_i drops.
- flush_i=1: state→EMPTY at the edge. Skid and main contents are discarded. No beat is accepted or delivered in the flush cycle.
- flush_cnt_o: at each flush edge (not reset), add the occupancy (0, 1 or 2). Saturate at 2^CNT_W−1, with no wrap.
- Upstream payload inputs are don't-care when in_valid_i=0. The skid is never loaded without a push.

Test Plan:
- Reset: assert srst 2 cycles with in_valid_i=1 -> out_valid_o=0, out_inst_o=32'h13, out_addr_o=0, flush_cnt_o=0. Release srst -> in_ready_o=1.
- Streaming: out_ready_i=1, push addr 0x0,0x4,0x8,0xC back-to-back -> each appears 1 cycle later in order, in_ready_o constantly 1, no gaps.
- Backpressure: out_ready_i=0, push 0x10,0x14 -> state FULL, in_ready_o=0, out_addr_o holds 0x10. Raise out_ready_i -> outputs 0x10 then 0x14, no loss or duplicate.
- Hold: state ONE with 0x20, hold_i=1 for 3 cycles with in_valid_i=1 and out_ready_i=1 -> out_valid_o=0, in_ready_o=0, nothing consumed. Drop hold -> 0x20 delivered once.
- Flush when FULL with hold_i=1 simultaneously -> next cycle EMPTY, flush_cnt_o increments by 2. Following push of 0x40 -> delivered next cycle with no stale entries.
- Saturation (CNT_W=2): 3 flushes with FULL occupancy -> flush_cnt_o goes 2, 3, 3.
